cpu_instruction_dumper: RTL and testbench

Readback counterpart to the instruction loader. On a host dump request it pauses a halted CPU and reads instruction RAM words 0..len-1. It streams them out through the UART transmitter, framed with the same 24-bit start/end words the loader accepts, so a dump can be replayed verbatim into the loader. It sits between the iRAM external read port and the `uart_tx` byte interface.

---
 rtl/cpu_loader_pkg.sv | 25 ++
 rtl/word_tx_serializer.sv | 45 ++++
 rtl/cpu_instruction_dumper.sv | 180 ++++++++++++++++++
 tb/tb_cpu_instruction_dumper.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the instruction loader and dumper: frame words, FSM states, iRAM width.
// The optional dump checksum is enabled with CPU_DUMP_CHECKSUM_EN.
package cpu_loader_pkg;

    localparam int unsigned IRAM_AW = 8;

    localparam logic [23:0] FRAME_START     = 24'hFF0000;
    localparam logic [23:0] FRAME_END_RESET = 24'hFFFF00;
    localparam logic [23:0] FRAME_END_KEEP  = 24'hFFF000;

    typedef enum logic [2:0] {
        StIdle,
        StStartFrame,
        StRead,
        StSend,
        StEndFrame,
        StCksum,
        StDone
    } dump_state_t;

    function automatic logic [7:0] word_xor(input logic [23:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16];
    endfunction

endpackage

// File: rtl/word_tx_serializer.sv
// Loads a 24-bit word and emits it LSB-first over a valid/ready byte interface.
// single_byte sends only bits [7:0]; word_sent pulses on the final accepted byte.
module word_tx_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] word,
    input  logic        single_byte,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        word_sent
);

    logic [23:0] word_q;
    logic [1:0]  left_q;
    logic        valid_q;
    logic        accept;

    assign accept    = valid_q & tx_ready;
    assign word_sent = accept & (left_q == 2'd0);
    assign tx_valid  = valid_q;
    assign tx_data   = word_q[7:0];

    // The owner only asserts load when idle or on the word_sent cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= 24'h000000;
            left_q  <= 2'd0;
            valid_q <= 1'b0;
        end else if (load) begin
            word_q  <= word;
            left_q  <= single_byte ? 2'd0 : 2'd2;
            valid_q <= 1'b1;
        end else if (accept) begin
            if (left_q == 2'd0) begin
                valid_q <= 1'b0;
            end else begin
                word_q <= {8'h00, word_q[23:8]};
                left_q <= left_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/cpu_instruction_dumper.sv
// Reads iRAM words 0..len-1 from a halted CPU and streams them framed to uart_tx for replay.
// Define CPU_DUMP_CHECKSUM_EN to append an XOR byte of the payload after the end frame.
module cpu_instruction_dumper
    import cpu_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dump_start,
    input  logic [LW-1:0]      dump_len,
    input  logic               HALT_flag,
    input  logic [23:0]        iRAM_data_out,
    input  logic               data_ack,
    input  logic               tx_ready,
    output logic               iRAM_read_enable,
    output logic [IRAM_AW-1:0] extern_iRAM_addr,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic               cpu_paused,
    output logic               busy,
    output logic               dump_done
);

    dump_state_t        state_q, state_d;
    logic [IRAM_AW-1:0] addr_q, addr_d;
    logic [LW-1:0]      rem_q, rem_d;
    logic               rd_en_q, rd_en_d;
    logic [23:0]        data_q, data_d;
    logic               loaded_q, loaded_d;
`ifdef CPU_DUMP_CHECKSUM_EN
    logic [7:0]         cksum_q, cksum_d;
`endif

    logic               ser_load;
    logic [23:0]        ser_word;
    logic               ser_single;
    logic               word_sent;

    word_tx_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load        (ser_load),
        .word        (ser_word),
        .single_byte (ser_single),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .word_sent   (word_sent)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_en_d    = rd_en_q;
        data_d     = data_q;
        loaded_d   = loaded_q;
        ser_load   = 1'b0;
        ser_word   = FRAME_START;
        ser_single = 1'b0;
`ifdef CPU_DUMP_CHECKSUM_EN
        cksum_d    = cksum_q;
`endif
        case (state_q)
            StIdle: begin
                if (dump_start && HALT_flag) begin
                    rem_d    = dump_len;
                    addr_d   = '0;
                    ser_load = 1'b1;
                    ser_word = FRAME_START;
                    state_d  = StStartFrame;
`ifdef CPU_DUMP_CHECKSUM_EN
                    cksum_d  = 8'h00;
`endif
                end
            end
            StStartFrame: begin
                if (word_sent) begin
                    if (rem_q == '0) begin
                        ser_load = 1'b1;
                        ser_word = FRAME_END_KEEP;
                        state_d  = StEndFrame;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (data_ack) begin
                    data_d   = iRAM_data_out;
                    rd_en_d  = 1'b0;
                    loaded_d = 1'b0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (!loaded_q) begin
                    ser_load = 1'b1;
                    ser_word = data_q;
                    loaded_d = 1'b1;
`ifdef CPU_DUMP_CHECKSUM_EN
                    cksum_d  = cksum_q ^ word_xor(data_q);
`endif
                end else if (word_sent) begin
                    // With len=256 the address wraps to 0 on the same beat remaining hits 0.
                    addr_d   = addr_q + 1'b1;
                    rem_d    = rem_q - 1'b1;
                    loaded_d = 1'b0;
                    if (rem_q == LW'(1)) begin
                        ser_load = 1'b1;
                        ser_word = FRAME_END_KEEP;
                        state_d  = StEndFrame;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StEndFrame: begin
                if (word_sent) begin
`ifdef CPU_DUMP_CHECKSUM_EN
                    ser_load   = 1'b1;
                    ser_word   = {16'h0000, cksum_q};
                    ser_single = 1'b1;
                    state_d    = StCksum;
`else
                    state_d    = StDone;
`endif
                end
            end
`ifdef CPU_DUMP_CHECKSUM_EN
            StCksum: begin
                if (word_sent) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            rem_q    <= '0;
            rd_en_q  <= 1'b0;
            data_q   <= 24'h000000;
            loaded_q <= 1'b0;
`ifdef CPU_DUMP_CHECKSUM_EN
            cksum_q  <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            rd_en_q  <= rd_en_d;
            data_q   <= data_d;
            loaded_q <= loaded_d;
`ifdef CPU_DUMP_CHECKSUM_EN
            cksum_q  <= cksum_d;
`endif
        end
    end

    assign iRAM_read_enable = rd_en_q;
    assign extern_iRAM_addr = addr_q;
    assign busy             = (state_q != StIdle);
    assign dump_done        = (state_q == StDone);
    assign cpu_paused       = busy && !dump_done;

endmodule

// File: tb/tb_cpu_instruction_dumper.sv
// Self-checking bench: byte-stream model built from the framing rules, checked every cycle.
module tb_cpu_instruction_dumper;

    logic        clk;
    logic        rst;
    logic        dump_start;
    logic [8:0]  dump_len;
    logic        HALT_flag;
    logic [23:0] iRAM_data_out;
    logic        data_ack;
    logic        tx_ready;
    logic        iRAM_read_enable;
    logic [7:0]  extern_iRAM_addr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        cpu_paused;
    logic        busy;
    logic        dump_done;

    cpu_instruction_dumper dut (
        .clk              (clk),
        .rst              (rst),
        .dump_start       (dump_start),
        .dump_len         (dump_len),
        .HALT_flag        (HALT_flag),
        .iRAM_data_out    (iRAM_data_out),
        .data_ack         (data_ack),
        .tx_ready         (tx_ready),
        .iRAM_read_enable (iRAM_read_enable),
        .extern_iRAM_addr (extern_iRAM_addr),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .cpu_paused       (cpu_paused),
        .busy             (busy),
        .dump_done        (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [0:255];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_log[$];
    int          rd_next;
    int          rd_count;
    int          lat;
    int          ready_mode;   // 0: held low, 1: toggling, 2: held high

    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        prev_en;
    logic [7:0]  prev_addr;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Expected byte stream for an accepted dump of len words.
    task automatic model_push(input int len);
        logic [23:0] w;
        logic [7:0]  x;
        x = 8'h00;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        for (int i = 0; i < len; i++) begin
            w = mem[i % 256];
            exp_q.push_back(w[7:0]); exp_q.push_back(w[15:8]); exp_q.push_back(w[23:16]);
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16];
        end
        exp_q.push_back(8'h00); exp_q.push_back(8'hF0); exp_q.push_back(8'hFF);
`ifdef CPU_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Compare process: byte stream, stall stability, read addresses, pause rule.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(tx_valid), 1);
                check("stall_data", int'(tx_data), int'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                rx_log.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    check("extra_byte", int'(tx_data), -1);
                end else begin
                    check("byte", int'(tx_data), int'(exp_q.pop_front()));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (iRAM_read_enable && !prev_en) begin
                check("rd_addr", int'(extern_iRAM_addr), rd_next % 256);
                rd_next++;
                rd_count++;
            end
            if (iRAM_read_enable && prev_en) begin
                check("rd_addr_stable", int'(extern_iRAM_addr), int'(prev_addr));
            end
            prev_en   = iRAM_read_enable;
            prev_addr = extern_iRAM_addr;
            check("paused_rule", int'(cpu_paused), int'(busy && !dump_done));
        end
    end

    // iRAM responder: acks lat cycles after a request is seen.
    initial begin
        int wait_cnt;
        wait_cnt      = 0;
        data_ack      = 1'b0;
        iRAM_data_out = 24'h000000;
        forever begin
            @(negedge clk);
            if (rst) begin
                data_ack = 1'b0;
                wait_cnt = 0;
            end else if (data_ack) begin
                data_ack = 1'b0;
            end else if (iRAM_read_enable) begin
                if (wait_cnt >= lat) begin
                    data_ack      = 1'b1;
                    iRAM_data_out = mem[extern_iRAM_addr];
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: tx_ready = 1'b0;
                1: tx_ready = ~tx_ready;
                default: tx_ready = 1'b1;
            endcase
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, int'(tx_valid), 0);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_rd_en"}, int'(iRAM_read_enable), 0);
        check({tag, "_addr"}, int'(extern_iRAM_addr), 0);
        check({tag, "_paused"}, int'(cpu_paused), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(dump_done), 0);
    endtask

    task automatic pulse_start(input int len, input bit halt);
        @(posedge clk); #1;
        HALT_flag  = halt;
        dump_len   = 9'(len);
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_dump(input int len, input bit halt, input bit extra_start,
                           input int exp_cycles);
        int cyc;
        rx_log.delete();
        rd_count = 0;
        rd_next  = 0;
        if (halt) model_push(len);
        pulse_start(len, halt);
        if (!halt) begin
            for (int i = 0; i < 10; i++) begin
                check("nohalt_busy", int'(busy), 0);
                @(negedge clk);
            end
            check("nohalt_bytes", rx_log.size(), 0);
            return;
        end
        check("first_byte_latency", int'(tx_valid), 1);
        check("paused_rise", int'(cpu_paused), 1);
        HALT_flag = 1'b0;
        if (extra_start) begin
            HALT_flag = 1'b1;
            pulse_start(5, 1'b1);
        end
        cyc = 0;
        while (!dump_done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", int'(cyc < 5000), 1);
        if (exp_cycles >= 0) check("dump_cycles", cyc, exp_cycles);
        check("paused_at_done", int'(cpu_paused), 0);
        check("exp_left", exp_q.size(), 0);
        check("rd_count", rd_count, len);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        exp_q.delete();
    endtask

    logic [7:0] lit [0:11];
    int         n;
    int         extra;

    initial begin
        lit = '{8'h00, 8'h00, 8'hFF, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hCD, 8'hAB, 8'h00, 8'hF0, 8'hFF};
`ifdef CPU_DUMP_CHECKSUM_EN
        extra = 1;
`else
        extra = 0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = {8'(i * 7 + 3), 8'(i), 8'(~i)};
        mem[0] = 24'h123456;
        mem[1] = 24'hABCDEF;
        rst = 1'b1; dump_start = 1'b0; dump_len = 9'd0; HALT_flag = 1'b0;
        lat = 0; ready_mode = 2; rd_next = 0; rd_count = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic two-word dump against hand-computed bytes and cycle count.
        do_dump(2, 1'b1, 1'b0, 16);
        for (int i = 0; i < 12; i++) begin
            if (i < rx_log.size()) check("lit_byte", int'(rx_log[i]), int'(lit[i]));
            else check("lit_missing", i, -1);
        end
        check("lit_count", rx_log.size(), 12 + extra);

        do_dump(3, 1'b0, 1'b0, -1);

        // Empty dump, plus a start pulse while busy that must be ignored.
        do_dump(0, 1'b1, 1'b1, -1);
        check("len0_bytes", rx_log.size(), 6 + extra);
`ifdef CPU_DUMP_CHECKSUM_EN
        if (rx_log.size() == 7) check("len0_cksum", int'(rx_log[6]), 0);
`endif

        ready_mode = 1; lat = 2;
        do_dump(3, 1'b1, 1'b0, -1);
        check("toggle_bytes", rx_log.size(), 15 + extra);

        ready_mode = 2; lat = 1;
        do_dump(256, 1'b1, 1'b0, -1);
        check("wrap_addr", int'(extern_iRAM_addr), 0);

`ifdef CPU_DUMP_CHECKSUM_EN
        mem[0] = 24'h0F00F0;
        lat = 0;
        do_dump(1, 1'b1, 1'b0, -1);
        n = rx_log.size();
        check("cksum_count", n, 10);
        if (n > 0) check("cksum_byte", int'(rx_log[n-1]), 8'hFF);
`endif

        // Reset after the 4th byte abandons the frame.
        rx_log.delete();
        rd_next = 0; rd_count = 0;
        model_push(256);
        pulse_start(256, 1'b1);
        n = 0;
        while (rx_log.size() < 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("rst_wait_timeout", int'(n < 200), 1);
        #1;
        rst = 1'b1;
        ready_mode = 0;
        exp_q.delete();
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        ready_mode = 2;
        n = rx_log.size();
        repeat (20) @(negedge clk);
        check("post_rst_bytes", rx_log.size(), n);
        check("post_rst_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
